// File: rtl/p405s_dcd_issue_pkg.sv
// Shared constants and types for the decode-stage issue buffer.
// Consumed by p405s_dcd_issue_buf and p405s_dcd_issue_ram2.
package p405s_dcd_issue_pkg;

  localparam int FLD_W_DEF = 17;
  localparam int CTL_W_DEF = 24;

  // Occupancy of the two-entry skid buffer doubles as the control state.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_e;

  typedef struct packed {
    logic [FLD_W_DEF-1:0] fld;
    logic [CTL_W_DEF-1:0] ctl;
  } entry_t;

endpackage

// File: rtl/p405s_dcd_issue_ram2.sv
// Two-entry register file for the issue buffer: one write slot, one read slot.
// Storage is cleared by a synchronous active-low reset so no X can reach the IFB.
module p405s_dcd_issue_ram2 #(
  parameter int W = 41
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         we,
  input  logic         wslot,
  input  logic [W-1:0] wdata,
  input  logic         rslot,
  output logic [W-1:0] rdata
);

  logic [W-1:0] mem [2];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
    end else if (we) begin
      mem[wslot] <= wdata;
    end
  end

  assign rdata = mem[rslot];

endmodule

// File: rtl/p405s_dcd_issue_buf.sv
// Decode-stage issue buffer: 2-entry skid FIFO feeding the execute IFB.
// Optional bubble counter is built only when P405S_DCD_ISSUE_PERF_EN is defined.
module p405s_dcd_issue_buf
  import p405s_dcd_issue_pkg::*;
#(
  parameter int FLD_W = FLD_W_DEF,
  parameter int CTL_W = CTL_W_DEF
) (
  input  logic             CB,
  input  logic             resetCore_Neg,
  input  logic             dcdValid,
  input  logic [FLD_W-1:0] dcdFldIn,
  input  logic [CTL_W-1:0] dcdCtlIn,
  input  logic             exeStall,
  input  logic             exeFlush,
  output logic             dcdHold,
  output logic [FLD_W-1:0] dcdFldOut,
  output logic [CTL_W-1:0] dcdCtlOut,
  output logic             exeDataE,
  output logic             exeDataSel,
  output logic             exeFlushorClear,
  output logic [1:0]       dcdBufCnt,
  output logic [15:0]      dcdBubbleCnt
);

  localparam int W = FLD_W + CTL_W;

  occ_e         cnt;
  logic         hd;
  logic         push;
  logic         pop;
  logic         wslot;
  logic [W-1:0] head_data;
  logic         empty;

  assign empty   = (cnt == EMPTY);
  assign dcdHold = (cnt == FULL);
  assign push    = dcdValid & ~dcdHold & ~exeFlush;
  assign pop     = ~empty & ~exeStall & ~exeFlush;
  // With at most one live entry the free slot is hd itself or its neighbour.
  assign wslot   = hd ^ (cnt == ONE);

  p405s_dcd_issue_ram2 #(.W(W)) u_ram (
    .clk   (CB),
    .rst_n (resetCore_Neg),
    .we    (push),
    .wslot (wslot),
    .wdata ({dcdFldIn, dcdCtlIn}),
    .rslot (hd),
    .rdata (head_data)
  );

  // Flush empties the buffer but leaves hd where it is.
  always_ff @(posedge CB) begin
    if (!resetCore_Neg) begin
      cnt <= EMPTY;
      hd  <= 1'b0;
    end else if (exeFlush) begin
      cnt <= EMPTY;
    end else begin
      if (pop) hd <= ~hd;
      unique case (cnt)
        EMPTY: if (push) cnt <= ONE;
        ONE: begin
          if (push && !pop)      cnt <= FULL;
          else if (!push && pop) cnt <= EMPTY;
        end
        FULL:  if (pop) cnt <= ONE;
        default: cnt <= EMPTY;
      endcase
    end
  end

  assign dcdFldOut       = empty ? '0 : head_data[W-1:CTL_W];
  assign dcdCtlOut       = empty ? '0 : head_data[CTL_W-1:0];
  assign exeDataE        = ~exeStall;
  assign exeDataSel      = empty | exeFlush;
  assign exeFlushorClear = exeFlush | empty;
  assign dcdBufCnt       = cnt;

`ifdef P405S_DCD_ISSUE_PERF_EN
  logic [15:0] bubble_cnt;

  // Counts cycles where the IFB loads a bubble; saturates rather than wraps.
  always_ff @(posedge CB) begin
    if (!resetCore_Neg) begin
      bubble_cnt <= 16'h0000;
    end else if (exeDataE && exeDataSel && bubble_cnt != 16'hFFFF) begin
      bubble_cnt <= bubble_cnt + 16'h0001;
    end
  end

  assign dcdBubbleCnt = bubble_cnt;
`else
  assign dcdBubbleCnt = 16'h0000;
`endif

endmodule

// File: tb/tb_p405s_dcd_issue_buf.sv
// Directed self-checking bench for p405s_dcd_issue_buf.
// Perf-counter checks follow P405S_DCD_ISSUE_PERF_EN like the RTL does.
module tb_p405s_dcd_issue_buf;

  localparam int FLD_W = 17;
  localparam int CTL_W = 24;

  logic             CB = 1'b0;
  logic             resetCore_Neg;
  logic             dcdValid;
  logic [FLD_W-1:0] dcdFldIn;
  logic [CTL_W-1:0] dcdCtlIn;
  logic             exeStall;
  logic             exeFlush;
  logic             dcdHold;
  logic [FLD_W-1:0] dcdFldOut;
  logic [CTL_W-1:0] dcdCtlOut;
  logic             exeDataE;
  logic             exeDataSel;
  logic             exeFlushorClear;
  logic [1:0]       dcdBufCnt;
  logic [15:0]      dcdBubbleCnt;

  int tests_run = 0;
  int tests_failed = 0;

  p405s_dcd_issue_buf #(.FLD_W(FLD_W), .CTL_W(CTL_W)) dut (
    .CB              (CB),
    .resetCore_Neg   (resetCore_Neg),
    .dcdValid        (dcdValid),
    .dcdFldIn        (dcdFldIn),
    .dcdCtlIn        (dcdCtlIn),
    .exeStall        (exeStall),
    .exeFlush        (exeFlush),
    .dcdHold         (dcdHold),
    .dcdFldOut       (dcdFldOut),
    .dcdCtlOut       (dcdCtlOut),
    .exeDataE        (exeDataE),
    .exeDataSel      (exeDataSel),
    .exeFlushorClear (exeFlushorClear),
    .dcdBufCnt       (dcdBufCnt),
    .dcdBubbleCnt    (dcdBubbleCnt)
  );

  always #5 CB = ~CB;

  task automatic applyStimulus(input logic v, input logic [FLD_W-1:0] f,
                               input logic [CTL_W-1:0] c, input logic st,
                               input logic fl);
    dcdValid = v;
    dcdFldIn = f;
    dcdCtlIn = c;
    exeStall = st;
    exeFlush = fl;
  endtask

  task automatic tick();
    @(posedge CB);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    // Reset held two cycles with decode still offering an instruction.
    resetCore_Neg = 1'b0;
    applyStimulus(1'b1, 17'h1FFFF, 24'hFFFFFF, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("rst_cnt",   32'(dcdBufCnt), 32'd0);
    checkOutput("rst_hold",  32'(dcdHold), 32'd0);
    checkOutput("rst_sel",   32'(exeDataSel), 32'd1);
    checkOutput("rst_clr",   32'(exeFlushorClear), 32'd1);
    checkOutput("rst_de",    32'(exeDataE), 32'd1);
    checkOutput("rst_fld",   32'(dcdFldOut), 32'd0);
    checkOutput("rst_ctl",   32'(dcdCtlOut), 32'd0);
    checkOutput("rst_bub",   32'(dcdBubbleCnt), 32'd0);

    // Streaming: each instruction appears one cycle after its push.
    resetCore_Neg = 1'b1;
    applyStimulus(1'b1, 17'h00001, 24'h000101, 1'b0, 1'b0);
    tick();
    checkOutput("str1_fld", 32'(dcdFldOut), 32'h00001);
    checkOutput("str1_ctl", 32'(dcdCtlOut), 32'h000101);
    checkOutput("str1_cnt", 32'(dcdBufCnt), 32'd1);
    checkOutput("str1_sel", 32'(exeDataSel), 32'd0);
    checkOutput("str1_clr", 32'(exeFlushorClear), 32'd0);
    applyStimulus(1'b1, 17'h00002, 24'h000202, 1'b0, 1'b0);
    tick();
    checkOutput("str2_fld", 32'(dcdFldOut), 32'h00002);
    checkOutput("str2_cnt", 32'(dcdBufCnt), 32'd1);
    applyStimulus(1'b1, 17'h00003, 24'h000303, 1'b0, 1'b0);
    tick();
    checkOutput("str3_fld", 32'(dcdFldOut), 32'h00003);
    checkOutput("str3_ctl", 32'(dcdCtlOut), 32'h000303);
    checkOutput("str3_sel", 32'(exeDataSel), 32'd0);
    applyStimulus(1'b0, 17'h0, 24'h0, 1'b0, 1'b0);
    tick();
    checkOutput("drain_cnt", 32'(dcdBufCnt), 32'd0);
    checkOutput("drain_fld", 32'(dcdFldOut), 32'd0);
    checkOutput("drain_sel", 32'(exeDataSel), 32'd1);

    // Fill under stall, third push refused, then drain in order.
    applyStimulus(1'b1, 17'h0AAAA, 24'hA0A0A0, 1'b1, 1'b0);
    tick();
    checkOutput("fillA_cnt",  32'(dcdBufCnt), 32'd1);
    checkOutput("fillA_fld",  32'(dcdFldOut), 32'h0AAAA);
    checkOutput("fillA_hold", 32'(dcdHold), 32'd0);
    checkOutput("fillA_de",   32'(exeDataE), 32'd0);
    applyStimulus(1'b1, 17'h15555, 24'h505050, 1'b1, 1'b0);
    tick();
    checkOutput("fillB_cnt",  32'(dcdBufCnt), 32'd2);
    checkOutput("fillB_hold", 32'(dcdHold), 32'd1);
    checkOutput("fillB_fld",  32'(dcdFldOut), 32'h0AAAA);
    applyStimulus(1'b1, 17'h1F0F0, 24'hF0F0F0, 1'b1, 1'b0);
    tick();
    checkOutput("refuse_cnt",  32'(dcdBufCnt), 32'd2);
    checkOutput("refuse_fld",  32'(dcdFldOut), 32'h0AAAA);
    checkOutput("refuse_hold", 32'(dcdHold), 32'd1);
    applyStimulus(1'b0, 17'h0, 24'h0, 1'b0, 1'b0);
    tick();
    checkOutput("popA_cnt",  32'(dcdBufCnt), 32'd1);
    checkOutput("popA_fld",  32'(dcdFldOut), 32'h15555);
    checkOutput("popA_ctl",  32'(dcdCtlOut), 32'h505050);
    checkOutput("popA_hold", 32'(dcdHold), 32'd0);
    tick();
    checkOutput("popB_cnt", 32'(dcdBufCnt), 32'd0);
    checkOutput("popB_fld", 32'(dcdFldOut), 32'd0);

    // hd is now 1: push X into slot 1, then push Y with a pop so Y wraps to slot 0.
    applyStimulus(1'b1, 17'h00111, 24'h111111, 1'b0, 1'b0);
    tick();
    checkOutput("wrapX_fld", 32'(dcdFldOut), 32'h00111);
    applyStimulus(1'b1, 17'h00222, 24'h222222, 1'b0, 1'b0);
    tick();
    checkOutput("wrapY_cnt", 32'(dcdBufCnt), 32'd1);
    checkOutput("wrapY_fld", 32'(dcdFldOut), 32'h00222);
    checkOutput("wrapY_ctl", 32'(dcdCtlOut), 32'h222222);
    applyStimulus(1'b0, 17'h0, 24'h0, 1'b0, 1'b0);
    tick();
    checkOutput("wrap_drain", 32'(dcdBufCnt), 32'd0);

    // Flush a full buffer while stalled and pushing.
    applyStimulus(1'b1, 17'h00AAA, 24'h0000AA, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b1, 17'h00BBB, 24'h0000BB, 1'b1, 1'b0);
    tick();
    checkOutput("preflush_cnt", 32'(dcdBufCnt), 32'd2);
    applyStimulus(1'b1, 17'h00CCC, 24'h0000CC, 1'b1, 1'b1);
    #1;
    checkOutput("flush_sel_now", 32'(exeDataSel), 32'd1);
    checkOutput("flush_clr_now", 32'(exeFlushorClear), 32'd1);
    tick();
    applyStimulus(1'b0, 17'h0, 24'h0, 1'b0, 1'b0);
    #1;
    checkOutput("flush_cnt",  32'(dcdBufCnt), 32'd0);
    checkOutput("flush_sel",  32'(exeDataSel), 32'd1);
    checkOutput("flush_ctl",  32'(dcdCtlOut), 32'd0);
    checkOutput("flush_fld",  32'(dcdFldOut), 32'd0);
    checkOutput("flush_hold", 32'(dcdHold), 32'd0);
    tick();
    checkOutput("flush_gone", 32'(dcdFldOut), 32'd0);
    applyStimulus(1'b1, 17'h00DDD, 24'h0000DD, 1'b0, 1'b0);
    tick();
    checkOutput("recover_fld", 32'(dcdFldOut), 32'h00DDD);

    // Reset mid-operation with a push in flight.
    applyStimulus(1'b1, 17'h00EEE, 24'h0000EE, 1'b1, 1'b0);
    tick();
    checkOutput("mid_precnt", 32'(dcdBufCnt), 32'd2);
    resetCore_Neg = 1'b0;
    applyStimulus(1'b1, 17'h00FFF, 24'h0000FF, 1'b0, 1'b0);
    tick();
    checkOutput("midrst_cnt",  32'(dcdBufCnt), 32'd0);
    checkOutput("midrst_fld",  32'(dcdFldOut), 32'd0);
    checkOutput("midrst_hold", 32'(dcdHold), 32'd0);

    // Bubble counter: 5 unstalled empty cycles count, 3 stalled ones do not.
    applyStimulus(1'b0, 17'h0, 24'h0, 1'b0, 1'b0);
    tick();
    resetCore_Neg = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    exeStall = 1'b1;
    for (int i = 0; i < 3; i++) tick();
`ifdef P405S_DCD_ISSUE_PERF_EN
    checkOutput("bub_count", 32'(dcdBubbleCnt), 32'd5);
    exeStall = 1'b0;
    force dut.bubble_cnt = 16'hFFFF;
    tick();
    release dut.bubble_cnt;
    tick();
    checkOutput("bub_sat", 32'(dcdBubbleCnt), 32'h0000FFFF);
`else
    checkOutput("bub_off", 32'(dcdBubbleCnt), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
